// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the layer-engine / pixel-mixer slice.
// Holds the line geometry, engine read latency, layer codes written into
// the scanline buffer, the sprite priority encoding, the engine pixel
// struct layouts and two small pixel helpers.
package ppu_pkg;

  // Line geometry and engine read latency.
  localparam int PPU_LINE_W   = 320;
  localparam int PPU_ADDR_W   = 9;
  localparam int PPU_READ_LAT = 2;

  // Layer code carried in the top two bits of every line-buffer word.
  typedef enum logic [1:0] {
    LYR_BACKDROP = 2'b00,
    LYR_BGR      = 2'b01,
    LYR_FGR      = 2'b10,
    LYR_SPR      = 2'b11
  } layer_e;

  // Sprite priority relative to the two tile layers.
  typedef enum logic [1:0] {
    SPR_PRIO_BELOW_BGR = 2'b00,
    SPR_PRIO_MID       = 2'b01,
    SPR_PRIO_TOP       = 2'b10,
    SPR_PRIO_TOP_ALT   = 2'b11
  } spr_prio_e;

  // Tile engine pixel: 16 palettes of 16 colors.
  typedef struct packed {
    logic [3:0] pal;
    logic [3:0] color;
  } tile_px_t;

  // Sprite engine pixel: 32 palettes of 16 colors.
  typedef struct packed {
    logic [4:0] pal;
    logic [3:0] color;
  } spr_px_t;

  // One scanline-buffer entry.
  typedef struct packed {
    layer_e     layer;
    logic [8:0] idx;
  } lbuf_word_t;

  // Color 0 is transparent in every palette; a disabled layer never shows.
  function automatic logic px_opaque(input logic en, input logic [3:0] color);
    return en && (color != 4'd0);
  endfunction

  // Tile palette references are zero-extended into the 9-bit index space.
  function automatic logic [8:0] tile_idx(input tile_px_t px);
    return {1'b0, px};
  endfunction

endpackage

// File: rtl/pmxr_priority_resolve.sv
// pmxr_priority_resolve: combinational per-pixel layer resolve.
// Picks the visible layer among background, foreground and sprite using
// transparency (color 0 or layer disabled) and the sprite priority, and
// forms the {layer, idx} word stored in the scanline buffer.
// Ports:
//   bgr_en_i, fgr_en_i, spr_en_i  layer enables
//   bgr_px_i, fgr_px_i            tile pixels {pal[3:0], color[3:0]}
//   spr_px_i                      sprite pixel {pal[4:0], color[3:0]}
//   spr_prio_i                    sprite priority code
//   mix_o                         resolved {layer[1:0], idx[8:0]}
module pmxr_priority_resolve
  import ppu_pkg::*;
(
  input  logic        bgr_en_i,
  input  logic        fgr_en_i,
  input  logic        spr_en_i,
  input  logic [7:0]  bgr_px_i,
  input  logic [7:0]  fgr_px_i,
  input  logic [8:0]  spr_px_i,
  input  logic [1:0]  spr_prio_i,
  output logic [10:0] mix_o
);

  tile_px_t   bgr_s;
  tile_px_t   fgr_s;
  spr_px_t    spr_s;
  spr_prio_e  prio_s;
  logic       bgr_op_s;
  logic       fgr_op_s;
  logic       spr_op_s;
  logic       spr_top_s;
  logic       spr_mid_s;
  logic       spr_low_s;
  lbuf_word_t mix_s;

  assign bgr_s  = tile_px_t'(bgr_px_i);
  assign fgr_s  = tile_px_t'(fgr_px_i);
  assign spr_s  = spr_px_t'(spr_px_i);
  assign prio_s = spr_prio_e'(spr_prio_i);

  assign bgr_op_s = px_opaque(bgr_en_i, bgr_s.color);
  assign fgr_op_s = px_opaque(fgr_en_i, fgr_s.color);
  assign spr_op_s = px_opaque(spr_en_i, spr_s.color);

  // Split an opaque sprite into the three priority slots it can occupy.
  always_comb begin
    spr_top_s = 1'b0;
    spr_mid_s = 1'b0;
    spr_low_s = 1'b0;
    case (prio_s)
      SPR_PRIO_TOP, SPR_PRIO_TOP_ALT: spr_top_s = spr_op_s;
      SPR_PRIO_MID:                   spr_mid_s = spr_op_s;
      SPR_PRIO_BELOW_BGR:             spr_low_s = spr_op_s;
      default:                        spr_low_s = 1'b0;
    endcase
  end

  // Highest visible layer wins; nothing opaque leaves the backdrop.
  always_comb begin
    mix_s = '{layer: LYR_BACKDROP, idx: 9'd0};
    if (spr_top_s) begin
      mix_s = '{layer: LYR_SPR, idx: spr_s};
    end else if (fgr_op_s) begin
      mix_s = '{layer: LYR_FGR, idx: tile_idx(fgr_s)};
    end else if (spr_mid_s) begin
      mix_s = '{layer: LYR_SPR, idx: spr_s};
    end else if (bgr_op_s) begin
      mix_s = '{layer: LYR_BGR, idx: tile_idx(bgr_s)};
    end else if (spr_low_s) begin
      mix_s = '{layer: LYR_SPR, idx: spr_s};
    end else begin
      mix_s = '{layer: LYR_BACKDROP, idx: 9'd0};
    end
  end

  assign mix_o = mix_s;

endmodule

// File: rtl/pixel_mixer.sv
// pixel_mixer: consumer end of the layer-engine pixel read interface.
// After prep it waits until every enabled engine reports its row ready,
// sweeps the shared pixel address 0..LINE_W-1 one per cycle, tracks each
// address through a READ_LAT-deep valid/address pipe so it lines up with
// the engine data, resolves the visible layer and writes one palette
// reference per pixel into the scanline buffer. done holds until the next
// prep; a prep in any active state abandons the current row.
// Ports:
//   clk, rst                     clock, async active-high reset
//   prep                         row start / restart pulse
//   bgr_en, fgr_en, spr_en       layer enables
//   bgr_done, fgr_done, spr_done engine row-ready flags
//   pmxr_pixel_addr              registered pixel address to the engines
//   bgr/fgr/spr_pixel_data       engine pixel data, READ_LAT after address
//   spr_pixel_prio               sprite priority for the current pixel
//   lbuf_wren/wraddr/wrdata      scanline buffer write port
//   done                         row complete
module pixel_mixer
  import ppu_pkg::*;
#(
  parameter int LINE_W   = PPU_LINE_W,
  parameter int ADDR_W   = PPU_ADDR_W,
  parameter int READ_LAT = PPU_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prep,
  input  logic              bgr_en,
  input  logic              fgr_en,
  input  logic              spr_en,
  input  logic              bgr_done,
  input  logic              fgr_done,
  input  logic              spr_done,
  output logic [ADDR_W-1:0] pmxr_pixel_addr,
  input  logic [7:0]        bgr_pixel_data,
  input  logic [7:0]        fgr_pixel_data,
  input  logic [8:0]        spr_pixel_data,
  input  logic [1:0]        spr_pixel_prio,
  output logic              lbuf_wren,
  output logic [ADDR_W-1:0] lbuf_wraddr,
  output logic [10:0]       lbuf_wrdata,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LINE_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              pipe_vld_q  [READ_LAT];
  logic [ADDR_W-1:0] pipe_addr_q [READ_LAT];
  logic              wren_q;
  logic              wren_d;
  logic [ADDR_W-1:0] wraddr_q;
  logic [ADDR_W-1:0] wraddr_d;
  logic [10:0]       wrdata_q;
  logic [10:0]       wrdata_d;
  logic              done_q;
  logic              done_d;
  logic              layers_ready_s;
  logic              issue_s;
  logic              flush_s;
  logic              last_wr_s;
  logic [10:0]       mix_s;

  // A disabled layer never holds up the sweep.
  assign layers_ready_s = (bgr_done | ~bgr_en) & (fgr_done | ~fgr_en) & (spr_done | ~spr_en);

  // The address on the bus is a real request only while sweeping.
  assign issue_s = (state_q == S_RUN);

  // The pipe tail carrying the final address is the row's last write.
  assign last_wr_s = pipe_vld_q[READ_LAT-1] && (pipe_addr_q[READ_LAT-1] == ADDR_LAST);

  pmxr_priority_resolve u_resolve (
    .bgr_en_i   (bgr_en),
    .fgr_en_i   (fgr_en),
    .spr_en_i   (spr_en),
    .bgr_px_i   (bgr_pixel_data),
    .fgr_px_i   (fgr_pixel_data),
    .spr_px_i   (spr_pixel_data),
    .spr_prio_i (spr_pixel_prio),
    .mix_o      (mix_s)
  );

  // Row sequencer and address sweep; prep overrides every state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    flush_s = 1'b0;
    if (prep) begin
      state_d = S_WAIT;
      addr_d  = '0;
      flush_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_WAIT: begin
          if (layers_ready_s) begin
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_RUN: begin
          // Address parks on the last pixel rather than wrapping.
          if (addr_q == ADDR_LAST) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (last_wr_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  // Write-port next state; the prep edge suppresses any in-flight write.
  always_comb begin
    wren_d   = pipe_vld_q[READ_LAT-1] & ~prep;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    if (wren_d) begin
      wraddr_d = pipe_addr_q[READ_LAT-1];
      wrdata_d = mix_s;
    end else begin
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
    end
    done_d = (state_q == S_DONE) & ~prep;
  end

  // Sequencer state and pixel address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Valid/address delay line matching the engine read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
    end else if (flush_s) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= issue_s;
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  // Registered line-buffer write port and done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= 11'd0;
      done_q   <= 1'b0;
    end else begin
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      done_q   <= done_d;
    end
  end

  assign pmxr_pixel_addr = addr_q;
  assign lbuf_wren       = wren_q;
  assign lbuf_wraddr     = wraddr_q;
  assign lbuf_wrdata     = wrdata_q;
  assign done            = done_q;

endmodule
